// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state type, default geometry and address field helpers for the L1 cache
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WTHRU = 2'd2
   } cache_state_t;

   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_SET_BITS  = 6;
   localparam int DEF_WORD_BITS = 3;

   function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb, input int width);
      return (addr >> lsb) & ((32'd1 << width) - 32'd1);
   endfunction

   function automatic logic [31:0] get_tag(input logic [31:0] addr, input int addr_w, input int set_bits,
                                           input int word_bits, input int byte_bits);
      return addr_field(addr, set_bits + word_bits + byte_bits, addr_w - set_bits - word_bits - byte_bits);
   endfunction

   function automatic logic [31:0] get_set(input logic [31:0] addr, input int set_bits,
                                           input int word_bits, input int byte_bits);
      return addr_field(addr, word_bits + byte_bits, set_bits);
   endfunction

   function automatic logic [31:0] get_word(input logic [31:0] addr, input int word_bits, input int byte_bits);
      return addr_field(addr, byte_bits, word_bits);
   endfunction

endpackage

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - miss-fill / write-through controller: state, fill counter, write capture, DRAM requests
module cache_fill_fsm
   import cache_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int WORD_BITS = DEF_WORD_BITS,
   parameter int BYTE_BITS = 1
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 wr,
   input  logic                 hit,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [DATA_W-1:0]    wdata,
   input  logic                 mem_data_valid,
   input  logic                 mem_wr_ack,
   output logic                 fsm_busy,
   output logic                 mem_rd_req,
   output logic                 mem_wr_req,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wr_data,
   output logic [WORD_BITS-1:0] fill_word,
   output logic                 fill_we,
   output logic                 line_we,
   output logic                 hit_we,
   output logic                 read_hit,
   output logic                 miss_start,
   output logic                 write_start
);

   localparam logic [WORD_BITS-1:0] LAST_WORD = '1;
   localparam logic [ADDR_W-1:0]    WORD_MASK = ~ADDR_W'((1 << BYTE_BITS) - 1);

   cache_state_t         state, state_next;
   logic [WORD_BITS-1:0] cnt;
   logic [ADDR_W-1:0]    wr_addr;

   assign fill_word = cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         wr_addr     <= '0;
         mem_wr_data <= '0;
      end else begin
         state <= state_next;
         if (miss_start)
            cnt <= '0;
         else if (fill_we)
            cnt <= cnt + WORD_BITS'(1);
         if (write_start) begin
            wr_addr     <= addr & WORD_MASK;
            mem_wr_data <= wdata;
         end
      end
   end

   always_comb begin
      state_next  = state;
      fsm_busy    = 1'b0;
      mem_rd_req  = 1'b0;
      mem_wr_req  = 1'b0;
      mem_addr    = '0;
      fill_we     = 1'b0;
      line_we     = 1'b0;
      hit_we      = 1'b0;
      read_hit    = 1'b0;
      miss_start  = 1'b0;
      write_start = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable) begin
               if (wr) begin
                  fsm_busy    = 1'b1;
                  write_start = 1'b1;
                  hit_we      = hit;
                  state_next  = WTHRU;
               end else if (hit) begin
                  read_hit = 1'b1;
               end else begin
                  fsm_busy   = 1'b1;
                  miss_start = 1'b1;
                  state_next = FILL;
               end
            end
         end
         FILL: begin
            // the core holds its address, so the line base comes straight from it
            fsm_busy   = 1'b1;
            mem_rd_req = 1'b1;
            mem_addr   = {addr[ADDR_W-1:WORD_BITS+BYTE_BITS], cnt, {BYTE_BITS{1'b0}}};
            if (mem_data_valid) begin
               fill_we = 1'b1;
               if (cnt == LAST_WORD) begin
                  line_we    = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         WTHRU: begin
            fsm_busy   = 1'b1;
            mem_wr_req = 1'b1;
            mem_addr   = wr_addr;
            if (mem_wr_ack)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: rtl/cache_memory_system.sv
// rtl/cache_memory_system.sv - parametrised direct-mapped write-through L1 cache; CACHE_STATS_EN adds hit/miss/write counters
module cache_memory_system
   import cache_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int SET_BITS  = DEF_SET_BITS,
   parameter int WORD_BITS = DEF_WORD_BITS
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              on_chip_wr,
   input  logic [ADDR_W-1:0] on_chip_memory_address,
   input  logic [DATA_W-1:0] on_chip_memory_data,
   output logic [DATA_W-1:0] data_out,
   output logic              fsm_busy,
   output logic              mem_rd_req,
   output logic              mem_wr_req,
   output logic [ADDR_W-1:0] off_chip_memory_address,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] off_chip_memory_data,
   input  logic              memory_data_valid,
   input  logic              mem_wr_ack
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]       stat_hits,
   output logic [31:0]       stat_misses,
   output logic [31:0]       stat_writes
`endif
);

   localparam int BYTE_BITS = (DATA_W == 32) ? 2 : 1;
   localparam int TAG_W     = ADDR_W - SET_BITS - WORD_BITS - BYTE_BITS;
   localparam int NSETS     = 1 << SET_BITS;
   localparam int NWORDS    = NSETS << WORD_BITS;

   logic [TAG_W-1:0]     tag_array [NSETS];
   logic [DATA_W-1:0]    data_array [NWORDS];
   logic [NSETS-1:0]     valid;

   logic [31:0]          addr32;
   logic [TAG_W-1:0]     tag;
   logic [SET_BITS-1:0]  set_idx;
   logic [WORD_BITS-1:0] word_idx, fill_word;
   logic                 hit, fill_we, line_we, hit_we, read_hit, miss_start, write_start;

   assign addr32   = 32'(on_chip_memory_address);
   assign tag      = TAG_W'(get_tag(addr32, ADDR_W, SET_BITS, WORD_BITS, BYTE_BITS));
   assign set_idx  = SET_BITS'(get_set(addr32, SET_BITS, WORD_BITS, BYTE_BITS));
   assign word_idx = WORD_BITS'(get_word(addr32, WORD_BITS, BYTE_BITS));

   assign hit      = valid[set_idx] && (tag_array[set_idx] == tag);
   assign data_out = read_hit ? data_array[{set_idx, word_idx}] : '0;

   cache_fill_fsm #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .WORD_BITS (WORD_BITS),
      .BYTE_BITS (BYTE_BITS)
   ) u_fsm (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .wr             (on_chip_wr),
      .hit            (hit),
      .addr           (on_chip_memory_address),
      .wdata          (on_chip_memory_data),
      .mem_data_valid (memory_data_valid),
      .mem_wr_ack     (mem_wr_ack),
      .fsm_busy       (fsm_busy),
      .mem_rd_req     (mem_rd_req),
      .mem_wr_req     (mem_wr_req),
      .mem_addr       (off_chip_memory_address),
      .mem_wr_data    (mem_wr_data),
      .fill_word      (fill_word),
      .fill_we        (fill_we),
      .line_we        (line_we),
      .hit_we         (hit_we),
      .read_hit       (read_hit),
      .miss_start     (miss_start),
      .write_start    (write_start)
   );

   // tags and data need no reset: the valid bits alone decide what is resident
   always_ff @(posedge clk) begin
      if (fill_we)
         data_array[{set_idx, fill_word}] <= off_chip_memory_data;
      else if (hit_we)
         data_array[{set_idx, word_idx}] <= on_chip_memory_data;
      if (line_we)
         tag_array[set_idx] <= tag;
   end

   always_ff @(posedge clk) begin
      if (rst)
         valid <= '0;
      else if (line_we)
         valid[set_idx] <= 1'b1;
   end

`ifdef CACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_hits   <= '0;
         stat_misses <= '0;
         stat_writes <= '0;
      end else begin
         if (read_hit && stat_hits != 32'hFFFF_FFFF)
            stat_hits <= stat_hits + 32'd1;
         if (miss_start && stat_misses != 32'hFFFF_FFFF)
            stat_misses <= stat_misses + 32'd1;
         if (write_start && stat_writes != 32'hFFFF_FFFF)
            stat_writes <= stat_writes + 32'd1;
      end
   end
`else
   logic unused_stat_events;
   assign unused_stat_events = miss_start ^ write_start;
`endif

endmodule

// File: tb/tb_cache_memory_system.sv
// tb/tb_cache_memory_system.sv - randomized self-checking bench against a behavioural cache/DRAM model
`timescale 1ns/1ps
module tb_cache_memory_system;

   logic        clk = 1'b0;
   logic        rst, enable, on_chip_wr, fsm_busy, mem_rd_req, mem_wr_req, mem_valid, mem_wr_ack;
   logic [15:0] addr_in, wdata_in, data_out, off_addr, mem_wr_data, dram_data;
`ifdef CACHE_STATS_EN
   logic [31:0] stat_hits, stat_misses, stat_writes;
`endif

   int checks   = 0;
   int failures = 0;

   // model: DRAM contents plus which tag each set holds (-1 = empty); cached data always equals DRAM
   logic [15:0] dram [int];
   int          res_tag [64];
   int          m_hits, m_misses, m_writes;

   always #5 clk = ~clk;

   cache_memory_system dut (
      .clk                     (clk),
      .rst                     (rst),
      .enable                  (enable),
      .on_chip_wr              (on_chip_wr),
      .on_chip_memory_address  (addr_in),
      .on_chip_memory_data     (wdata_in),
      .data_out                (data_out),
      .fsm_busy                (fsm_busy),
      .mem_rd_req              (mem_rd_req),
      .mem_wr_req              (mem_wr_req),
      .off_chip_memory_address (off_addr),
      .mem_wr_data             (mem_wr_data),
      .off_chip_memory_data    (dram_data),
      .memory_data_valid       (mem_valid),
      .mem_wr_ack              (mem_wr_ack)
`ifdef CACHE_STATS_EN
      ,
      .stat_hits               (stat_hits),
      .stat_misses             (stat_misses),
      .stat_writes             (stat_writes)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] dram_rd(input int a);
      if (dram.exists(a))
         return dram[a];
      return 16'((a * 40503) ^ 32'h3C5A);
   endfunction

   function automatic int tag_of(input int a);
      return a / 1024;
   endfunction

   function automatic int set_of(input int a);
      return (a / 16) % 64;
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < 64; s++)
         res_tag[s] = -1;
      m_hits   = 0;
      m_misses = 0;
      m_writes = 0;
   endfunction

   task automatic check_quiet(input string tag);
      check_val({tag, "_busy"}, fsm_busy, 0);
      check_val({tag, "_reqs"}, {mem_rd_req, mem_wr_req}, 0);
      check_val({tag, "_addr"}, off_addr, 0);
   endtask

   // called on a negedge; returns on a negedge with enable low
   task automatic do_read(input logic [15:0] a, input int abort_after);
      bit exp_hit;
      int nval, cyc;
      logic [15:0] fa;
      exp_hit    = (res_tag[set_of(a)] == tag_of(a));
      enable     = 1'b1;
      on_chip_wr = 1'b0;
      addr_in    = a;
      #1;
      check_val("rd_busy_first", fsm_busy, !exp_hit);
      if (!exp_hit) begin
         m_misses++;
         nval = 0;
         cyc  = 0;
         @(negedge clk);
         while (fsm_busy && cyc < 200) begin
            check_val("fill_reqs", {mem_rd_req, mem_wr_req}, 2'b10);
            if (abort_after >= 0 && nval == abort_after) begin
               mem_valid = 1'b0;
               rst       = 1'b1;
               enable    = 1'b0;
               @(negedge clk);
               check_quiet("abort");
               check_val("abort_data", data_out, 0);
               rst = 1'b0;
               model_reset();
               return;
            end
            if ($urandom_range(0, 3) != 0) begin
               fa = (a & 16'hFFF0) | 16'(nval * 2);
               check_val("fill_addr", off_addr, fa);
               mem_valid = 1'b1;
               dram_data = dram_rd(fa);
               nval++;
            end else begin
               mem_valid = 1'b0;
               dram_data = 16'($urandom);
            end
            @(negedge clk);
            cyc++;
         end
         mem_valid = 1'b0;
         check_val("fill_words", nval, 8);
         res_tag[set_of(a)] = tag_of(a);
      end
      // the re-presented (or first) request is an enabled read hit this cycle
      m_hits++;
      check_val("rd_busy_done", fsm_busy, 0);
      check_val("rd_reqs_done", {mem_rd_req, mem_wr_req}, 0);
      check_val("rd_data", data_out, dram_rd(a & 16'hFFFE));
      @(negedge clk);
      enable = 1'b0;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int delay);
      enable     = 1'b1;
      on_chip_wr = 1'b1;
      addr_in    = a;
      wdata_in   = d;
      #1;
      check_val("wr_busy_first", fsm_busy, 1);
      m_writes++;
      @(negedge clk);
      for (int k = 0; k <= delay; k++) begin
         check_val("wr_reqs", {mem_rd_req, mem_wr_req, fsm_busy}, 3'b011);
         check_val("wr_addr", off_addr, a & 16'hFFFE);
         check_val("wr_data", mem_wr_data, d);
         wdata_in = 16'($urandom);
         if (k == delay) begin
            mem_wr_ack = 1'b1;
            enable     = 1'b0;
         end
         @(negedge clk);
      end
      mem_wr_ack = 1'b0;
      on_chip_wr = 1'b0;
      check_val("wr_busy_done", fsm_busy, 0);
      check_val("wr_req_done", mem_wr_req, 0);
      dram[a & 16'hFFFE] = d;
   endtask

   // stray DRAM strobes while idle must be ignored
   task automatic idle_cycle();
      enable     = 1'b0;
      mem_valid  = 1'($urandom);
      mem_wr_ack = 1'($urandom);
      dram_data  = 16'($urandom);
      #1;
      check_quiet("idle");
      @(negedge clk);
      mem_valid  = 1'b0;
      mem_wr_ack = 1'b0;
   endtask

   initial begin
      int op;
      logic [15:0] ra;
      rst        = 1'b1;
      enable     = 1'b0;
      on_chip_wr = 1'b0;
      addr_in    = '0;
      wdata_in   = '0;
      mem_valid  = 1'b0;
      mem_wr_ack = 1'b0;
      dram_data  = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_quiet("reset");
      check_val("reset_data", data_out, 0);
      check_val("reset_wdata", mem_wr_data, 0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++)
         dram[16'h1230 + 2 * i] = 16'hA000 + 16'(i);
      do_read(16'h1234, -1);
      do_read(16'h1234, -1);
      check_val("dir_a002", data_out, 16'hA002);
      do_write(16'h1236, 16'hBEEF, 5);
      do_read(16'h1236, -1);
      do_write(16'h8000, 16'h1111, 2);
      do_read(16'h8000, -1);
      do_read(16'h0040, -1);
      do_read(16'h0440, -1);
      do_read(16'h0040, -1);
      do_read(16'h2000, 3);
      do_read(16'h2000, -1);
      idle_cycle();

      do_read(16'h3000, -1);
      for (int i = 0; i < 3; i++)
         do_read(16'h3004, -1);
      do_write(16'h3002, 16'h5A5A, 1);

      for (int n = 0; n < 300; n++) begin
         ra = 16'($urandom_range(0, 3) * 1024 + $urandom_range(0, 3) * 16 + $urandom_range(0, 7) * 2);
         op = $urandom_range(0, 9);
         if (op < 6)
            do_read(ra, -1);
         else if (op < 9)
            do_write(ra, 16'($urandom), $urandom_range(0, 3));
         else
            idle_cycle();
      end

`ifdef CACHE_STATS_EN
      check_val("stat_hits", stat_hits, m_hits);
      check_val("stat_misses", stat_misses, m_misses);
      check_val("stat_writes", stat_writes, m_writes);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
